// File: rtl/rt_pixel_scheduler.sv
// rt_pixel_scheduler: round-robin pixel job dispatch across render cores with
// in-order fragment collection into a single raster-ordered output stream.
module rt_pixel_scheduler #(
  parameter int NUM_CORES = 4,
  parameter int COORD_W = 16,
  parameter int FRAG_W = 32
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        start_i,
  input  logic [COORD_W-1:0]          image_width_i,
  input  logic [COORD_W-1:0]          image_height_i,
  output logic                        busy_o,
  output logic                        done_o,
  output logic [NUM_CORES-1:0]        job_valid_o,
  input  logic [NUM_CORES-1:0]        job_ready_i,
  output logic [COORD_W-1:0]          job_x_o,
  output logic [COORD_W-1:0]          job_y_o,
  input  logic [NUM_CORES-1:0]        res_valid_i,
  output logic [NUM_CORES-1:0]        res_ready_o,
  input  logic [NUM_CORES*FRAG_W-1:0] res_frag_i,
  output logic                        out_valid_o,
  input  logic                        out_ready_i,
  output logic [FRAG_W-1:0]           out_frag_o,
  output logic                        out_last_o
);
  localparam int PW = NUM_CORES > 1 ? $clog2(NUM_CORES) : 1;
  localparam int CW = 2 * COORD_W;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q;
  logic [COORD_W-1:0] w_q, h_q, x_q, y_q;
  logic [CW-1:0] total, dispatched_q, collected_q;
  logic [PW-1:0] dptr_q, cptr_q;
  logic [NUM_CORES-1:0] pending_q, pending_d;
  logic [FRAG_W-1:0] out_frag_q;
  logic out_valid_q, out_last_q;
  logic disp_ok, disp_fire, coll_ok, coll_fire, out_free, last_x;
  always_comb begin
    total = CW'(w_q) * CW'(h_q);
    out_free = !out_valid_q || out_ready_i;
    last_x = x_q == w_q - 1'b1;
    disp_ok = state_q == RUN && dispatched_q < total && !pending_q[dptr_q];
    disp_fire = disp_ok && job_ready_i[dptr_q];
    coll_ok = state_q == RUN && pending_q[cptr_q] && out_free;
    coll_fire = coll_ok && res_valid_i[cptr_q];
    job_valid_o = '0;
    job_valid_o[dptr_q] = disp_ok;
    res_ready_o = '0;
    res_ready_o[cptr_q] = coll_ok;
    // set after clear: a core re-dispatched in its own collect cycle stays pending
    pending_d = pending_q;
    if (coll_fire) pending_d[cptr_q] = 1'b0;
    if (disp_fire) pending_d[dptr_q] = 1'b1;
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      w_q <= '0;
      h_q <= '0;
      x_q <= '0;
      y_q <= '0;
      dispatched_q <= '0;
      collected_q <= '0;
      dptr_q <= '0;
      cptr_q <= '0;
      pending_q <= '0;
      out_frag_q <= '0;
      out_valid_q <= 1'b0;
      out_last_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start_i) begin
          w_q <= image_width_i;
          h_q <= image_height_i;
          x_q <= '0;
          y_q <= '0;
          dispatched_q <= '0;
          collected_q <= '0;
          dptr_q <= '0;
          cptr_q <= '0;
          pending_q <= '0;
          state_q <= (image_width_i == '0 || image_height_i == '0) ? DONE : RUN;
        end
        RUN: begin
          pending_q <= pending_d;
          if (disp_fire) begin
            x_q <= last_x ? '0 : x_q + 1'b1;
            y_q <= last_x ? y_q + 1'b1 : y_q;
            dptr_q <= dptr_q == PW'(NUM_CORES - 1) ? '0 : dptr_q + 1'b1;
            dispatched_q <= dispatched_q + 1'b1;
          end
          if (coll_fire) begin
            out_frag_q <= res_frag_i[cptr_q*FRAG_W +: FRAG_W];
            out_valid_q <= 1'b1;
            out_last_q <= collected_q == total - CW'(1);
            cptr_q <= cptr_q == PW'(NUM_CORES - 1) ? '0 : cptr_q + 1'b1;
            collected_q <= collected_q + 1'b1;
          end else if (out_ready_i) begin
            out_valid_q <= 1'b0;
            out_last_q <= 1'b0;
          end
          if (out_valid_q && out_ready_i && out_last_q) state_q <= DONE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign busy_o = state_q == RUN;
  assign done_o = state_q == DONE;
  assign job_x_o = x_q;
  assign job_y_o = y_q;
  assign out_valid_o = out_valid_q;
  assign out_frag_o = out_frag_q;
  assign out_last_o = out_last_q;
endmodule
